agu_nd: RTL and testbench

- Parametrised N-dimensional address generation unit; successor to the fixed 4-counter AGU used by the MVU operand fetch paths.
- Walks a nested loop nest of NDIM levels: programmable base address, per-level lengths and per-level signed jumps.
- Emits one address per accepted beat over a valid/ready handshake, flags loop-level carries and signals the last beat.
- Runs as a one-shot job launched by `start`; sits between the MVU controller and the RAM read/write ports.

---
 rtl/agu_pkg.sv | 35 +++
 rtl/agu_nd_if.sv | 26 ++
 rtl/agu_dim_cnt.sv | 23 ++
 rtl/agu_nd.sv | 140 ++++++++++++++
 tb/tb_agu_nd.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/agu_pkg.sv
// Package for the N-dimensional address generation unit (agu_nd).
// Holds the default geometry, the FSM state type and helpers that pull one
// level's length or jump out of the flat packed configuration buses.
package agu_pkg;

  localparam int AGU_BWADDR   = 21;
  localparam int AGU_BWLENGTH = 8;
  localparam int AGU_NDIM     = 5;

  // Widest flat config bus the slicing helpers accept (8 levels x 32 bits).
  localparam int AGU_MAXVEC = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Generic field extractor: level k of a vector packed with bw-bit fields,
  // level 0 in the LSBs. Callers truncate the result to their field width.
  function automatic logic [31:0] agu_field(input logic [AGU_MAXVEC-1:0] vec,
                                            input int bw, input int k);
    return 32'(vec >> (k * bw));
  endfunction

  function automatic logic [31:0] len_field(input logic [AGU_MAXVEC-1:0] vec,
                                            input int bwlength, input int k);
    return agu_field(vec, bwlength, k);
  endfunction

  function automatic logic [31:0] jump_field(input logic [AGU_MAXVEC-1:0] vec,
                                             input int bwaddr, input int k);
    return agu_field(vec, bwaddr, k);
  endfunction

endpackage

// File: rtl/agu_nd_if.sv
// Address stream interface between agu_nd and its consumer (RAM port).
//
// Handshake: a beat transfers on a rising clk edge where addr_valid and
// addr_ready are both 1 ("fire"). While addr_valid=1 and addr_ready=0 the
// producer holds addr_out steady; addr_valid never drops before its beat
// fires. zc_out/last_out are qualified by fire and are 0 otherwise.
//
// Signals: addr_valid, addr_ready, addr_out[BWADDR], zc_out[NDIM-1], last_out.
// Modports: master (agu_nd), slave (consumer).
interface agu_nd_if
  import agu_pkg::*;
#(
  parameter int BWADDR = AGU_BWADDR,
  parameter int NDIM   = AGU_NDIM
);
  logic              addr_valid;
  logic              addr_ready;
  logic [BWADDR-1:0] addr_out;
  logic [NDIM-2:0]   zc_out;
  logic              last_out;

  modport master (output addr_valid, output addr_out, output zc_out,
                  output last_out, input addr_ready);
  modport slave  (input addr_valid, input addr_out, input zc_out,
                  input last_out, output addr_ready);
endinterface

// File: rtl/agu_dim_cnt.sv
// One loop level of agu_nd: a down counter with load, decrement and a zero
// flag. Load wins over decrement; clr (sync, active-high) wins over both.
// Ports: clk, clr, load, dec, load_val[BWLENGTH], zero.
module agu_dim_cnt #(
  parameter int BWLENGTH = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                load,
  input  logic                dec,
  input  logic [BWLENGTH-1:0] load_val,
  output logic                zero
);
  logic [BWLENGTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clr)       count <= '0;
    else if (load) count <= load_val;
    else if (dec)  count <= count - BWLENGTH'(1);
  end

  assign zero = (count == '0);
endmodule

// File: rtl/agu_nd.sv
// agu_nd: N-dimensional address generation unit. Walks a loop nest of NDIM
// levels (NDIM-1 length counters plus an outermost jump) from a base address,
// emitting one address per fired beat on the agu_nd_if master port.
//
// Ports: clk, clr (sync, active-high), start, base[BWADDR],
//        lengths[(NDIM-1)*BWLENGTH], jumps[NDIM*BWADDR], busy,
//        dbg_state (FSM state), bus (agu_nd_if.master).
// Optional macro AGU_ND_CONT_EN: adds input cont; a job launched with cont=1
//        wraps forever (adds the outermost jump, reloads every counter) and
//        only clr stops it.
module agu_nd
  import agu_pkg::*;
#(
  parameter int BWADDR   = AGU_BWADDR,
  parameter int BWLENGTH = AGU_BWLENGTH,
  parameter int NDIM     = AGU_NDIM
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         start,
`ifdef AGU_ND_CONT_EN
  input  logic                         cont,
`endif
  input  logic [BWADDR-1:0]            base,
  input  logic [(NDIM-1)*BWLENGTH-1:0] lengths,
  input  logic [NDIM*BWADDR-1:0]       jumps,
  output logic                         busy,
  output state_t                       dbg_state,
  agu_nd_if.master                     bus
);

  state_t state_q, state_d;

  logic [NDIM-2:0][BWLENGTH-1:0] len_q, len_in, cnt_val;
  logic [NDIM-1:0][BWADDR-1:0]   jump_q, jump_in;
  logic [BWADDR-1:0]             addr_q, jsel;
  logic [NDIM-2:0]               zero, pre_zero, cnt_load, cnt_dec;
  logic                          fire, launch, all_zero, finish, advance;
  logic                          cont_q;
  logic                          acc, found;

  assign fire     = bus.addr_valid & bus.addr_ready;
  assign launch   = (state_q == IDLE) & start;
  assign all_zero = pre_zero[NDIM-2];
  // Final beat ends the job unless it was launched in continuous mode.
  assign finish   = fire & all_zero & ~cont_q;
  assign advance  = fire & ~finish;

  always_comb begin
    for (int k = 0; k < NDIM - 1; k++)
      len_in[k] = BWLENGTH'(len_field(AGU_MAXVEC'(lengths), BWLENGTH, k));
    for (int k = 0; k < NDIM; k++)
      jump_in[k] = BWADDR'(jump_field(AGU_MAXVEC'(jumps), BWADDR, k));
  end

  // pre_zero[k]: counters 0..k all zero. Levels below the first non-zero
  // counter (m) reload; level m itself decrements; higher levels hold.
  always_comb begin
    pre_zero = '0;
    cnt_load = '0;
    cnt_dec  = '0;
    cnt_val  = len_q;
    acc      = 1'b1;
    for (int k = 0; k < NDIM - 1; k++) begin
      cnt_dec[k]  = advance & ~zero[k] & acc;
      acc         = acc & zero[k];
      pre_zero[k] = acc;
      cnt_load[k] = launch | (advance & acc);
      if (launch) cnt_val[k] = len_in[k];
    end
  end

  // Jump select: j[m] for the first non-zero level, j[NDIM-1] on a wrap.
  always_comb begin
    jsel  = jump_q[NDIM-1];
    found = 1'b0;
    for (int k = 0; k < NDIM - 1; k++) begin
      if (!found && !zero[k]) begin
        jsel  = jump_q[k];
        found = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NDIM - 1; k++) begin : g_cnt
    agu_dim_cnt #(.BWLENGTH(BWLENGTH)) u_cnt (
      .clk      (clk),
      .clr      (clr),
      .load     (cnt_load[k]),
      .dec      (cnt_dec[k]),
      .load_val (cnt_val[k]),
      .zero     (zero[k])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = RUN;
      RUN:     if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      jump_q  <= '0;
`ifdef AGU_ND_CONT_EN
      cont_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q <= base;
        len_q  <= len_in;
        jump_q <= jump_in;
`ifdef AGU_ND_CONT_EN
        cont_q <= cont;
`endif
      end else if (advance) begin
        addr_q <= addr_q + jsel;  // modulo 2^BWADDR, jumps are two's complement
      end
    end
  end

`ifndef AGU_ND_CONT_EN
  assign cont_q = 1'b0;
`endif

  assign busy           = (state_q == RUN);
  assign dbg_state      = state_q;
  assign bus.addr_valid = (state_q == RUN);
  assign bus.addr_out   = addr_q;
  assign bus.zc_out     = fire ? pre_zero : '0;
  assign bus.last_out   = fire & all_zero;

endmodule

// File: tb/tb_agu_nd.sv
// Directed bench for agu_nd with NDIM=3, BWADDR=21, BWLENGTH=8.
module tb_agu_nd;
  import agu_pkg::*;

  localparam int AW = 21;
  localparam int LW = 8;
  localparam int ND = 3;

  logic                   clk = 1'b0;
  logic                   clr;
  logic                   start;
  logic                   cont;
  logic [AW-1:0]          base;
  logic [(ND-1)*LW-1:0]   lengths;
  logic [ND*AW-1:0]       jumps;
  logic                   busy;
  state_t                 dbg_state;

  agu_nd_if #(.BWADDR(AW), .NDIM(ND)) bus ();

  agu_nd #(.BWADDR(AW), .BWLENGTH(LW), .NDIM(ND)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
`ifdef AGU_ND_CONT_EN
    .cont      (cont),
`endif
    .base      (base),
    .lengths   (lengths),
    .jumps     (jumps),
    .busy      (busy),
    .dbg_state (dbg_state),
    .bus       (bus.master)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [AW-1:0]   exp_q[$];
  logic [ND-2:0]   exp_zc_q[$];
  logic            exp_last_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic [ND-2:0] zc, input logic last);
    exp_q.push_back(a);
    exp_zc_q.push_back(zc);
    exp_last_q.push_back(last);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    clr = 1'b1; start = 1'b0; cont = 1'b0; base = '0; lengths = '0; jumps = '0;
    bus.addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  // Called at posedge+1 in IDLE; returns at posedge+1 with the job in RUN.
  task automatic start_job(input logic [AW-1:0] b, input logic [(ND-1)*LW-1:0] l,
                           input logic [ND*AW-1:0] j, input logic c);
    start = 1'b1; base = b; lengths = l; jumps = j; cont = c;
    @(posedge clk); #1;
    // Scramble inputs: the job must run from the latched copy.
    start = 1'b0; cont = 1'b0;
    base = AW'($urandom); lengths = (ND-1)*LW'($urandom); jumps = {$urandom, $urandom};
  endtask

  // Drains the expected queue; rnd randomises addr_ready, poke pulses start mid-run.
  task automatic run_job(input string name, input bit rnd, input int poke, input bit ends);
    int cyc;
    logic [AW-1:0] last_addr;
    cyc = 0;
    last_addr = '0;
    while (exp_q.size() > 0 && cyc < 400) begin
      bus.addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (cyc == poke);
      if (cyc == poke) base = 21'h3FF;
      @(negedge clk);
      check({name, "_valid"}, 32'(bus.addr_valid), 32'd1);
      check({name, "_addr"}, 32'(bus.addr_out), 32'(exp_q[0]));
      if (bus.addr_ready) begin
        check({name, "_zc"}, 32'(bus.zc_out), 32'(exp_zc_q[0]));
        check({name, "_last"}, 32'(bus.last_out), 32'(exp_last_q[0]));
        last_addr = exp_q.pop_front();
        void'(exp_zc_q.pop_front());
        void'(exp_last_q.pop_front());
      end else begin
        check({name, "_zc_idle"}, 32'(bus.zc_out), 32'd0);
        check({name, "_last_idle"}, 32'(bus.last_out), 32'd0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.addr_ready = 1'b1;
    check({name, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete(); exp_zc_q.delete(); exp_last_q.delete();
    if (ends) begin
      @(negedge clk);
      check({name, "_busy_end"}, 32'(busy), 32'd0);
      check({name, "_valid_end"}, 32'(bus.addr_valid), 32'd0);
      check({name, "_addr_hold"}, 32'(bus.addr_out), 32'(last_addr));
      check({name, "_state_end"}, 32'(dbg_state), 32'(IDLE));
      @(posedge clk); #1;
    end
  endtask

  task automatic push_basic();
    push_beat(21'h100, 2'b00, 1'b0);
    push_beat(21'h101, 2'b01, 1'b0);
    push_beat(21'h111, 2'b00, 1'b0);
    push_beat(21'h112, 2'b01, 1'b0);
    push_beat(21'h122, 2'b00, 1'b0);
    push_beat(21'h123, 2'b11, 1'b1);
  endtask

  localparam logic [(ND-1)*LW-1:0] BASIC_L = {8'd2, 8'd1};
  localparam logic [ND*AW-1:0]     BASIC_J = {21'h40, 21'h10, 21'h1};

  // ---------------- main sequence ----------------
  initial begin
    int fires;
    int cyc;
    do_reset();

    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus.addr_valid), 32'd0);
    check("rst_addr", 32'(bus.addr_out), 32'd0);
    check("rst_zc", 32'(bus.zc_out), 32'd0);
    check("rst_last", 32'(bus.last_out), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;

    // Basic walk, ready held high.
    push_basic();
    start_job(21'h100, BASIC_L, BASIC_J, 1'b0);
    run_job("basic", 1'b0, -1, 1'b1);

    // Backpressure plus a start pulse while running (must be ignored).
    push_basic();
    start_job(21'h100, BASIC_L, BASIC_J, 1'b0);
    run_job("bp", 1'b1, 3, 1'b1);

    // Negative jump with wrap below zero.
    push_beat(21'h000005, 2'b00, 1'b0);
    push_beat(21'h000003, 2'b00, 1'b0);
    push_beat(21'h000001, 2'b00, 1'b0);
    push_beat(21'h1FFFFF, 2'b11, 1'b1);
    start_job(21'h5, {8'd0, 8'd3}, {21'h0, 21'h0, 21'h1FFFFE}, 1'b0);
    run_job("neg", 1'b0, -1, 1'b1);

    // Degenerate single-beat job.
    push_beat(21'h42, 2'b11, 1'b1);
    start_job(21'h42, '0, {21'h7, 21'h5, 21'h3}, 1'b0);
    run_job("degen", 1'b0, -1, 1'b1);

    // clr after the third beat discards the job.
    bus.addr_ready = 1'b1;
    start_job(21'h100, BASIC_L, BASIC_J, 1'b0);
    fires = 0;
    cyc = 0;
    while (fires < 3 && cyc < 50) begin
      @(negedge clk);
      if (bus.addr_valid && bus.addr_ready) fires++;
      cyc++;
    end
    check("clr_fires", 32'(fires), 32'd3);
    check("clr_third_addr", 32'(bus.addr_out), 32'h111);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("clr_valid", 32'(bus.addr_valid), 32'd0);
      check("clr_addr", 32'(bus.addr_out), 32'd0);
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_state", 32'(dbg_state), 32'(IDLE));
    end
    @(posedge clk); #1;

    // A fresh job after clr starts from the programmed lengths.
    push_basic();
    start_job(21'h100, BASIC_L, BASIC_J, 1'b0);
    run_job("after_clr", 1'b0, -1, 1'b1);

`ifdef AGU_ND_CONT_EN
    // Continuous mode: l={0,1}, wrap adds j[2]=0x10.
    push_beat(21'h00, 2'b00, 1'b0);
    push_beat(21'h01, 2'b11, 1'b1);
    push_beat(21'h11, 2'b00, 1'b0);
    push_beat(21'h12, 2'b11, 1'b1);
    push_beat(21'h22, 2'b00, 1'b0);
    push_beat(21'h23, 2'b11, 1'b1);
    start_job(21'h0, {8'd0, 8'd1}, {21'h10, 21'h0, 21'h1}, 1'b1);
    run_job("cont", 1'b0, -1, 1'b0);
    @(negedge clk);
    check("cont_busy", 32'(busy), 32'd1);
    check("cont_addr", 32'(bus.addr_out), 32'h33);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("cont_clr_busy", 32'(busy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time guard so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
